reg_writeback: RTL

Writeback sequencer that drives the register file write side (in_reg/sel_in/flags_in) from execute-stage results. Accepts one retiring instruction per handshake: ALU result, single-word load, or load-multiple. Issues memory reads for loads and serialises all register writes onto the single write port. Signals PC increment when r15 was not written.

---
 rtl/reg_writeback_pkg.sv | 28 ++
 rtl/reg_writeback_if.sv | 33 +++
 rtl/reg_writeback_lowest_set_bit.sv | 16 +
 rtl/reg_writeback.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_writeback_pkg.sv
// Shared CPU definitions for the writeback slice: retire kinds, FSM states, flag positions.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam logic [3:0]  PC_INDEX = 4'd15;

    // NZCV bit positions within the flags nibble
    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        KindAlu   = 2'd0,
        KindLoad  = 2'd1,
        KindLoadm = 2'd2,
        KindNop   = 2'd3
    } wb_kind_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoadWait,
        StMultiReq,
        StMultiWait,
        StBaseWb
    } wb_state_e;

endpackage

// File: rtl/reg_writeback_if.sv
// Execute-to-writeback handshake plus the memory read bus used by the writeback sequencer.
interface reg_writeback_if;
    import cpu_pkg::*;

    logic              wb_valid;
    logic              wb_ready;
    wb_kind_e          wb_kind;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [3:0]        wb_flags;
    logic              wb_set_flags;
    logic [15:0]       wb_reglist;

    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output wb_valid, wb_kind, wb_rd, wb_data, wb_flags, wb_set_flags, wb_reglist,
        input  wb_ready,
        input  mem_req, mem_addr,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  wb_valid, wb_kind, wb_rd, wb_data, wb_flags, wb_set_flags, wb_reglist,
        output wb_ready,
        output mem_req, mem_addr,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/reg_writeback_lowest_set_bit.sv
// 16-bit priority encoder: index of the lowest set bit and a valid flag.
module lowest_set_bit (
    input  logic [15:0] mask_i,
    output logic [3:0]  idx_o,
    output logic        valid_o
);

    always_comb begin
        idx_o   = 4'd0;
        valid_o = |mask_i;
        for (int i = 15; i >= 0; i--) begin
            if (mask_i[i]) idx_o = 4'(i);
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Writeback sequencer serialising ALU, load and load-multiple results onto one register write port.
// Optional REG_WRITEBACK_BASE_EN adds base-register writeback after a load-multiple.
module reg_writeback
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_STEP   = 4,
    parameter int unsigned MEM_TIMEOUT = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    reg_writeback_if.slave    bus,
    output logic [DATA_W-1:0] in_reg,
    output logic [3:0]        sel_in,
    output logic              reg_we,
    output logic [3:0]        flags_in,
    output logic              flags_we,
    output logic              pc_inc,
    output logic              mem_err
);

    wb_state_e         state_q, state_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [3:0]        rd_q, rd_d;
    logic [15:0]       mask_q, mask_d;
    logic              wrote_pc_q, wrote_pc_d;
    logic [31:0]       timer_q, timer_d;
    logic              err_q, err_d;
    logic              reg_we_q, reg_we_d;
    logic [3:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              flags_we_q, flags_we_d;
    logic [3:0]        flags_q, flags_d;
    logic              pc_inc_q, pc_inc_d;
`ifdef REG_WRITEBACK_BASE_EN
    logic              rd_in_mask_q, rd_in_mask_d;
`endif

    logic [3:0] lsb_idx;
    logic       lsb_valid;
    logic       wait_expired;

    lowest_set_bit u_lsb (
        .mask_i  (mask_q),
        .idx_o   (lsb_idx),
        .valid_o (lsb_valid)
    );

    assign wait_expired = (MEM_TIMEOUT != 0) && (timer_q == MEM_TIMEOUT - 32'd1);

    assign bus.wb_ready = (state_q == StIdle);
    assign bus.mem_req  = (state_q == StLoadWait) || (state_q == StMultiWait);
    assign bus.mem_addr = addr_q;

    assign in_reg   = data_q;
    assign sel_in   = sel_q;
    assign reg_we   = reg_we_q;
    assign flags_in = flags_q;
    assign flags_we = flags_we_q;
    assign pc_inc   = pc_inc_q;
    assign mem_err  = err_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        mask_d     = mask_q;
        wrote_pc_d = wrote_pc_q;
        timer_d    = timer_q;
        err_d      = err_q;
        reg_we_d   = 1'b0;
        sel_d      = sel_q;
        data_d     = data_q;
        flags_we_d = 1'b0;
        flags_d    = flags_q;
        pc_inc_d   = 1'b0;
`ifdef REG_WRITEBACK_BASE_EN
        rd_in_mask_d = rd_in_mask_q;
`endif

        case (state_q)
            StIdle: begin
                if (bus.wb_valid) begin
                    case (bus.wb_kind)
                        KindAlu: begin
                            reg_we_d = 1'b1;
                            sel_d    = bus.wb_rd;
                            data_d   = bus.wb_data;
                            pc_inc_d = (bus.wb_rd != PC_INDEX);
                            if (bus.wb_set_flags) begin
                                flags_we_d = 1'b1;
                                flags_d    = bus.wb_flags;
                            end
                        end
                        KindLoad: begin
                            addr_d  = bus.wb_data;
                            rd_d    = bus.wb_rd;
                            timer_d = 32'd0;
                            state_d = StLoadWait;
                        end
                        KindLoadm: begin
                            addr_d     = bus.wb_data;
                            rd_d       = bus.wb_rd;
                            mask_d     = bus.wb_reglist;
                            wrote_pc_d = bus.wb_reglist[PC_INDEX];
`ifdef REG_WRITEBACK_BASE_EN
                            rd_in_mask_d = bus.wb_reglist[bus.wb_rd];
`endif
                            // An empty list retires immediately like a NOP
                            if (bus.wb_reglist == 16'd0) pc_inc_d = 1'b1;
                            else                         state_d  = StMultiReq;
                        end
                        default: pc_inc_d = 1'b1;
                    endcase
                end
            end

            StLoadWait: begin
                if (bus.mem_ack) begin
                    reg_we_d = 1'b1;
                    sel_d    = rd_q;
                    data_d   = bus.mem_rdata;
                    pc_inc_d = (rd_q != PC_INDEX);
                    state_d  = StIdle;
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            StMultiReq: begin
                timer_d = 32'd0;
                if (lsb_valid) begin
                    state_d = StMultiWait;
                end else begin
                    pc_inc_d = !wrote_pc_q;
                    state_d  = StIdle;
                end
            end

            StMultiWait: begin
                if (bus.mem_ack) begin
                    reg_we_d = 1'b1;
                    sel_d    = lsb_idx;
                    data_d   = bus.mem_rdata;
                    mask_d   = mask_q & ~(16'd1 << lsb_idx);
                    addr_d   = addr_q + DATA_W'(ADDR_STEP);
                    if (mask_d != 16'd0) begin
                        state_d = StMultiReq;
                    end else begin
`ifdef REG_WRITEBACK_BASE_EN
                        // addr_d already equals base + ADDR_STEP * popcount(mask)
                        if (!rd_in_mask_q) begin
                            state_d = StBaseWb;
                        end else begin
                            pc_inc_d = !wrote_pc_q;
                            state_d  = StIdle;
                        end
`else
                        pc_inc_d = !wrote_pc_q;
                        state_d  = StIdle;
`endif
                    end
                end else if (wait_expired) begin
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end

            StBaseWb: begin
                reg_we_d = 1'b1;
                sel_d    = rd_q;
                data_d   = addr_q;
                pc_inc_d = !(wrote_pc_q || (rd_q == PC_INDEX));
                state_d  = StIdle;
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            rd_q       <= '0;
            mask_q     <= '0;
            wrote_pc_q <= 1'b0;
            timer_q    <= '0;
            err_q      <= 1'b0;
            reg_we_q   <= 1'b0;
            sel_q      <= '0;
            data_q     <= '0;
            flags_we_q <= 1'b0;
            flags_q    <= '0;
            pc_inc_q   <= 1'b0;
`ifdef REG_WRITEBACK_BASE_EN
            rd_in_mask_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rd_q       <= rd_d;
            mask_q     <= mask_d;
            wrote_pc_q <= wrote_pc_d;
            timer_q    <= timer_d;
            err_q      <= err_d;
            reg_we_q   <= reg_we_d;
            sel_q      <= sel_d;
            data_q     <= data_d;
            flags_we_q <= flags_we_d;
            flags_q    <= flags_d;
            pc_inc_q   <= pc_inc_d;
`ifdef REG_WRITEBACK_BASE_EN
            rd_in_mask_q <= rd_in_mask_d;
`endif
        end
    end

endmodule
